// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display blocks.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // One complete display set: what is shown, which points are lit, which digits are on.
    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  en;
    } disp_set_t;

    localparam disp_set_t DISP_RESET = '{value: 32'h0, dp: 8'h00, en: 8'hFF};

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment glyph.
// Latency: combinational. Backpressure: none.
// Shared by every display block that needs a hex glyph.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (hex)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with frame-aligned double-buffered loads.
// Latency: all display outputs registered, one cycle behind the scan state.
// Backpressure: none; load_req always accepted, last request before the frame boundary wins.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int SLOT_CYCLES  = 5000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clk_100mHz_in,
    input  logic        reset,
    input  logic [31:0] value_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en_in,
    input  logic        load_req,
    output logic        load_ack,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_start
);

    localparam logic [15:0] SLOT_LAST  = 16'(SLOT_CYCLES - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
    localparam logic [2:0]  DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [15:0] slot_cnt;
    logic [2:0]  digit_idx;
    scan_state_t state;

    disp_set_t   load_set;
    disp_set_t   stage_set;
    disp_set_t   act_set;
    logic        pending;
    logic        committed;

    logic        slot_wrap;
    logic        commit_pt;
    logic [6:0]  dec_seg_n;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign commit_pt = slot_wrap && (digit_idx == DIGIT_LAST);
    assign load_set  = '{value: value_in, dp: dp_in, en: digit_en_in};

    always_ff @(posedge clk_100mHz_in or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            state     <= ST_BLANK;
        end else begin
            if (slot_wrap) begin
                slot_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
                state     <= ST_BLANK;
            end else begin
                slot_cnt <= slot_cnt + 16'd1;
                if (slot_cnt == BLANK_LAST) begin
                    state <= ST_DRIVE;
                end
            end
        end
    end

    // The active set only moves at the digit-7 -> digit-0 wrap, so a frame never mixes values.
    // A request landing exactly on that boundary skips staging and goes live immediately.
    always_ff @(posedge clk_100mHz_in or posedge reset) begin
        if (reset) begin
            stage_set <= DISP_RESET;
            act_set   <= DISP_RESET;
            pending   <= 1'b0;
            committed <= 1'b0;
        end else begin
            committed <= commit_pt && (pending || load_req);
            if (load_req) begin
                stage_set <= load_set;
            end
            if (commit_pt) begin
                if (load_req) begin
                    act_set <= load_set;
                end else if (pending) begin
                    act_set <= stage_set;
                end
                pending <= 1'b0;
            end else if (load_req) begin
                pending <= 1'b1;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .hex   (act_set.value[{digit_idx, 2'b00} +: 4]),
        .seg_n (dec_seg_n)
    );

    // load_ack is taken from a delayed commit flag so it lands on the same cycle as frame_start.
    always_ff @(posedge clk_100mHz_in or posedge reset) begin
        if (reset) begin
            an_n        <= 8'hFF;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            frame_start <= (slot_cnt == 16'd0) && (digit_idx == 3'd0);
            load_ack    <= committed;
            if ((state == ST_DRIVE) && act_set.en[digit_idx]) begin
                an_n  <= ~(8'b1 << digit_idx);
                seg_n <= dec_seg_n;
                dp_n  <= ~act_set.dp[digit_idx];
            end else begin
                an_n  <= 8'hFF;
                seg_n <= SEG_BLANK;
                dp_n  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with 8-cycle slots and 2-cycle blanking.
module tb_seven_seg_scan_ctrl;

    logic        clk_100mHz_in = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] value_in = 32'h0;
    logic [7:0]  dp_in = 8'h00;
    logic [7:0]  digit_en_in = 8'h00;
    logic        load_req = 1'b0;
    logic        load_ack;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_start;

    int passed = 0;
    int total  = 0;
    logic [7:0] ld_en = 8'hFF;
    logic [7:0] ld_dp = 8'h00;

    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_scan_ctrl #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk_100mHz_in (clk_100mHz_in),
        .reset         (reset),
        .value_in      (value_in),
        .dp_in         (dp_in),
        .digit_en_in   (digit_en_in),
        .load_req      (load_req),
        .load_ack      (load_ack),
        .an_n          (an_n),
        .seg_n         (seg_n),
        .dp_n          (dp_n),
        .frame_start   (frame_start)
    );

    always #5 clk_100mHz_in = ~clk_100mHz_in;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s @%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic chk_reset(input int cyc);
        chk("rst_an_n", cyc, 32'(an_n), 32'hFF);
        chk("rst_seg_n", cyc, 32'(seg_n), 32'h7F);
        chk("rst_dp_n", cyc, 32'(dp_n), 32'h1);
        chk("rst_load_ack", cyc, 32'(load_ack), 32'h0);
        chk("rst_frame_start", cyc, 32'(frame_start), 32'h0);
    endtask

    // Runs ncyc output cycles of one frame (first sample is frame cycle 0), checking every
    // output against the expected display set, and pulses load_req after samples la1/la2.
    task automatic run_frame(input logic [31:0] val, input logic [7:0] en, input logic [7:0] dp,
                             input bit ack_exp, input int ncyc,
                             input int la1, input logic [31:0] lv1,
                             input int la2, input logic [31:0] lv2);
        for (int i = 0; i < ncyc; i++) begin
            int         dig;
            int         slot;
            logic       drv;
            logic [3:0] nib;
            logic [7:0] exp_an;
            logic [6:0] exp_seg;
            logic       exp_dp;
            @(negedge clk_100mHz_in);
            dig  = i / 8;
            slot = i % 8;
            drv  = (slot >= 2) && en[dig];
            nib  = 4'(val >> (4 * dig));
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            if (drv) begin
                exp_an       = 8'hFF;
                exp_an[dig]  = 1'b0;
                exp_seg      = GLYPH[nib];
                exp_dp       = ~dp[dig];
            end
            chk("an_n", i, 32'(an_n), 32'(exp_an));
            chk("seg_n", i, 32'(seg_n), 32'(exp_seg));
            chk("dp_n", i, 32'(dp_n), 32'(exp_dp));
            chk("frame_start", i, 32'(frame_start), 32'(i == 0));
            chk("load_ack", i, 32'(load_ack), 32'((i == 0) && ack_exp));
            load_req    = (i == la1) || (i == la2);
            value_in    = (i == la2) ? lv2 : lv1;
            dp_in       = ld_dp;
            digit_en_in = ld_en;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_100mHz_in);
        chk_reset(-1);
        reset = 1'b0;

        // Idle scan of zeros; mid-frame load shows from the next frame.
        run_frame(32'h0, 8'hFF, 8'h00, 1'b0, 64, 20, 32'h89AB_CDEF, -1, 32'h0);
        // Two loads in one frame: last wins, one ack.
        run_frame(32'h89AB_CDEF, 8'hFF, 8'h00, 1'b1, 64, 10, 32'h1111_1111, 40, 32'h2222_2222);
        // Load in the commit cycle, with partial enables and digit-0 point.
        ld_en = 8'b1111_0101;
        ld_dp = 8'h01;
        run_frame(32'h2222_2222, 8'hFF, 8'h00, 1'b1, 64, 62, 32'h3456_789A, -1, 32'h0);
        run_frame(32'h3456_789A, 8'hF5, 8'h01, 1'b1, 64, -1, 32'h0, -1, 32'h0);
        // Pending load, then reset during digit 4 DRIVE.
        ld_en = 8'hFF;
        ld_dp = 8'h00;
        run_frame(32'h3456_789A, 8'hF5, 8'h01, 1'b0, 36, 10, 32'hDEAD_BEEF, -1, 32'h0);
        #1 reset = 1'b1;
        #1 chk_reset(-2);
        repeat (2) @(negedge clk_100mHz_in);
        chk_reset(-3);
        reset = 1'b0;
        run_frame(32'h0, 8'hFF, 8'h00, 1'b0, 64, -1, 32'h0, -1, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
